// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute sequencer with Rd/Wr/Mem_Ack handshake, bus timeout and fault codes.
// Defining MU0_SINGLE_STEP_EN adds a Step input and a PAUSE state after every completed instruction.
module mu0_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_Ack,
`ifdef MU0_SINGLE_STEP_EN
  input  logic       Step,
`endif
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] M,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic [1:0] Fault
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;

  localparam logic [3:0] TO_LIM = 4'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t     state_q, state_d, done_st;
  logic [3:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

`ifdef MU0_SINGLE_STEP_EN
  assign done_st = S_PAUSE;
`else
  assign done_st = S_FETCH;
`endif

  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = 2'b00;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    Fault    = fault_q;
    state_d  = state_q;
    wait_d   = wait_q;
    fault_d  = fault_q;

    case (state_q)
      S_FETCH: begin
        Rd    = 1'b1;
        X_sel = 1'b1;
        M     = 2'b10;
        if (Mem_Ack) begin
          IR_En   = 1'b1;
          PC_En   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (F)
          4'h0, 4'h2, 4'h3: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            M        = (F == 4'h0) ? 2'b00 : ((F == 4'h2) ? 2'b01 : 2'b11);
            if (Mem_Ack) begin
              Acc_En  = 1'b1;
              state_d = done_st;
            end
          end
          4'h1: begin
            Addr_sel = 1'b1;
            Wr       = 1'b1;
            if (Mem_Ack) state_d = done_st;
          end
          4'h4, 4'h5, 4'h6: begin
            if ((F == 4'h4) || (F == 4'h5 && !N) || (F == 4'h6 && !Z)) begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            state_d = done_st;
          end
          4'h7: begin
            state_d = S_HALT;
            fault_d = 2'b00;
          end
          default: begin
            state_d = S_HALT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_HALT: Halted = 1'b1;
      S_PAUSE: begin
`ifdef MU0_SINGLE_STEP_EN
        if (Step) state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Timeout overrides the access only when Mem_Ack is still low in the limit cycle.
    if ((Rd || Wr) && !Mem_Ack) begin
      wait_d = wait_q + 4'd1;
      if (TO_EN && wait_q == TO_LIM) begin
        state_d = S_HALT;
        fault_d = 2'b10;
        wait_d  = '0;
      end
    end else begin
      wait_d = '0;
    end

    if (!Reset) begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      M        = 2'b00;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Halted   = 1'b0;
      Fault    = 2'b00;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: runs small MU0 programs through mu0_control with a behavioural datapath/memory
// and scoreboards every completed bus transaction; also exercises wait states, timeout and faults.
module tb_mu0_control;

`ifdef MU0_SINGLE_STEP_EN
  localparam int SS = 1;
`else
  localparam int SS = 0;
`endif

  logic       Clk, Reset;
  logic [3:0] F;
  logic       N, Z, Mem_Ack;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted;
  logic [1:0] M, Fault;
`ifdef MU0_SINGLE_STEP_EN
  logic       Step;
`endif

  mu0_control #(.TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ack(Mem_Ack),
`ifdef MU0_SINGLE_STEP_EN
    .Step(Step),
`endif
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En), .IR_En(IR_En),
    .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr), .Halted(Halted), .Fault(Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural datapath and memory.
  logic [15:0] mem [0:4095];
  logic [11:0] pc = '0;
  logic [15:0] ir = '0, acc = '0;
  logic [15:0] x, y, alu, din;
  logic [11:0] addr;
  int          ack_cnt = 0;
  int          ack_delay = 0;
  bit          ack_never = 1'b0;

  always_comb begin
    x    = X_sel ? {4'h0, pc} : acc;
    addr = Addr_sel ? ir[11:0] : pc;
    din  = mem[addr];
    y    = Y_sel ? {4'h0, ir[11:0]} : din;
    case (M)
      2'b00:   alu = y;
      2'b01:   alu = x + y;
      2'b10:   alu = x + 16'd1;
      default: alu = x - y;
    endcase
    Mem_Ack = (Rd || Wr) && !ack_never && (ack_cnt >= ack_delay);
  end

  assign F = ir[15:12];
  assign N = acc[15];
  assign Z = (acc == 16'h0000);

  logic [12:0] ctrl;
  assign ctrl = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Fault};

  // Scoreboard: {wr, addr, write data (0 for reads)}.
  logic [28:0] exp_q [$];
  int rd_cyc = 0, acc_en_cnt = 0, jmp_cnt = 0;

  logic        c_rst = 1'b0, c_ir_en = 1'b0, c_pc_en = 1'b0, c_acc_en = 1'b0;
  logic        c_rdwr = 1'b0, c_ack = 1'b0;
  logic [15:0] c_alu = '0, c_din = '0;

  always @(negedge Clk) begin
    logic [28:0] obs, e;
    if (Reset && (Rd || Wr) && Mem_Ack) begin
      obs = {Wr, addr, (Wr ? x : 16'h0000)};
      if (exp_q.size() == 0) chk("sb_extra", 32'(obs), 32'h1FFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_txn", 32'(obs), 32'(e));
      end
    end
    if (Rd) rd_cyc++;
    if (Acc_En) acc_en_cnt++;
    if ((PC_En || IR_En || Acc_En) && (Rd || Wr)) chk("en_need_ack", 32'(Mem_Ack), 32'd1);
    if (PC_En && !IR_En) begin
      jmp_cnt++;
      chk("jmp_sel", 32'({M, Y_sel, X_sel, Addr_sel, Rd, Wr}), 32'b0010000);
    end
    c_rst = Reset; c_ir_en = IR_En; c_pc_en = PC_En; c_acc_en = Acc_En;
    c_rdwr = Rd || Wr; c_ack = Mem_Ack; c_alu = alu; c_din = din;
  end

  always @(posedge Clk) begin
    if (!c_rst) begin
      pc <= '0; ir <= '0; acc <= '0; ack_cnt <= 0;
    end else begin
      if (c_ir_en)  ir  <= c_din;
      if (c_pc_en)  pc  <= c_alu[11:0];
      if (c_acc_en) acc <= c_alu;
      ack_cnt <= (c_rdwr && !c_ack) ? ack_cnt + 1 : 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic push_rd(input logic [11:0] a);
    exp_q.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic do_reset(input int n);
    @(posedge Clk); #1 Reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk("rst_out_zero", 32'(ctrl), 32'd0);
    end
    @(posedge Clk); #1 Reset = 1'b1;
  endtask

  task automatic run_halt(input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge Clk);
      if (Halted === 1'b1) break;
      cyc++;
      if (cyc > budget) begin
        chk("halt_budget", 32'(cyc), 32'(budget));
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int cyc, r0, a0, j0;
    Reset = 1'b0;
`ifdef MU0_SINGLE_STEP_EN
    Step = 1'b1;
`endif

    // 1: LDA/ADD/STA/STP, zero wait states
    clear_mem();
    mem[12'h000] = 16'h0010; mem[12'h001] = 16'h2011;
    mem[12'h002] = 16'h1012; mem[12'h003] = 16'h7000;
    mem[12'h010] = 16'd5;    mem[12'h011] = 16'd7;
    push_rd(12'h000); push_rd(12'h010); push_rd(12'h001); push_rd(12'h011);
    push_rd(12'h002); push_wr(12'h012, 16'h000C); push_rd(12'h003);
    do_reset(2);
    run_halt(60, cyc);
    chk("t1_cycles", 32'(cyc), 32'(8 + 3 * SS));
    chk("t1_halt_fault", 32'({Halted, Fault}), 32'b100);
    chk("t1_acc", 32'(acc), 32'h000C);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: three wait states on every access
    clear_mem();
    mem[12'h000] = 16'h0010; mem[12'h001] = 16'h7000; mem[12'h010] = 16'h1234;
    ack_delay = 3;
    push_rd(12'h000); push_rd(12'h010); push_rd(12'h001);
    do_reset(1);
    r0 = rd_cyc; a0 = acc_en_cnt;
    run_halt(60, cyc);
    chk("t2_cycles", 32'(cyc), 32'(13 + SS));
    chk("t2_rd_cycles", 32'(rd_cyc - r0), 32'd12);
    chk("t2_acc_en_once", 32'(acc_en_cnt - a0), 32'd1);
    chk("t2_acc", 32'(acc), 32'h1234);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    ack_delay = 0;

    // 3: conditional jumps, taken and not taken
    clear_mem();
    mem[12'h000] = 16'h0020; mem[12'h001] = 16'h5004; mem[12'h002] = 16'h6005;
    mem[12'h003] = 16'h7000; mem[12'h004] = 16'h7000; mem[12'h005] = 16'h0021;
    mem[12'h006] = 16'h6003; mem[12'h007] = 16'h5009; mem[12'h008] = 16'h9000;
    mem[12'h009] = 16'h7000; mem[12'h020] = 16'h8000; mem[12'h021] = 16'h0000;
    push_rd(12'h000); push_rd(12'h020); push_rd(12'h001); push_rd(12'h002); push_rd(12'h005);
    push_rd(12'h021); push_rd(12'h006); push_rd(12'h007); push_rd(12'h009);
    do_reset(1);
    j0 = jmp_cnt;
    run_halt(80, cyc);
    chk("t3_cycles", 32'(cyc), 32'(14 + 6 * SS));
    chk("t3_taken_jumps", 32'(jmp_cnt - j0), 32'd2);
    chk("t3_halt_fault", 32'({Halted, Fault}), 32'b100);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: illegal opcode, then a one-cycle reset restarts fetch
    clear_mem();
    mem[12'h000] = 16'h9000;
    push_rd(12'h000);
    do_reset(1);
    run_halt(20, cyc);
    chk("t4_cycles", 32'(cyc), 32'd2);
    chk("t4_halt_fault", 32'({Halted, Fault}), 32'b101);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("t4_halt_quiet", 32'(ctrl), 32'b0000000000101);
    end
    push_rd(12'h000);
    do_reset(1);
    @(negedge Clk);
    chk("t4_refetch", 32'({Rd, Addr_sel, Halted, Fault}), 32'b10000);
    run_halt(20, cyc);
    chk("t4_refault", 32'({cyc[3:0], Halted, Fault}), 32'b0001101);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-access, then fetch timeout, then ack in the last allowed cycle
    clear_mem();
    mem[12'h000] = 16'h7000;
    ack_never = 1'b1;
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("t5_rd_waiting", 32'({Rd, Addr_sel}), 32'b10);
    end
    do_reset(1);
    r0 = rd_cyc;
    run_halt(40, cyc);
    chk("t5_to_cycles", 32'(cyc), 32'd16);
    chk("t5_to_rd_cycles", 32'(rd_cyc - r0), 32'd16);
    chk("t5_to_fault", 32'({Halted, Fault, Rd, Wr}), 32'b11000);
    ack_never = 1'b0;
    ack_delay = 15;
    push_rd(12'h000);
    do_reset(1);
    run_halt(40, cyc);
    chk("t5_late_ack_cycles", 32'(cyc), 32'd17);
    chk("t5_late_ack_fault", 32'({Halted, Fault}), 32'b100);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    ack_delay = 0;

`ifdef MU0_SINGLE_STEP_EN
    // 6: PAUSE after ADD until Step
    clear_mem();
    mem[12'h000] = 16'h2010; mem[12'h001] = 16'h7000; mem[12'h010] = 16'd3;
    push_rd(12'h000); push_rd(12'h010); push_rd(12'h001);
    Step = 1'b0;
    do_reset(1);
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("t6_pause_idle", 32'(ctrl), 32'd0);
    end
    @(posedge Clk); #1 Step = 1'b1;
    @(negedge Clk);
    chk("t6_step_cycle", 32'(ctrl), 32'd0);
    @(posedge Clk); #1 Step = 1'b0;
    @(negedge Clk);
    chk("t6_next_fetch", 32'({Rd, Addr_sel, Halted}), 32'b100);
    run_halt(20, cyc);
    chk("t6_cycles", 32'(cyc), 32'd1);
    chk("t6_acc", 32'(acc), 32'd3);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
